// File: rtl/sha3_chi_if.sv
// Chi-stage state bus: five input planes plus sample, five result planes plus good/busy.
// overrun is present only when SHA3_CHI_OVERRUN_EN is defined.
interface sha3_chi_if;
  logic [63:0] isa [0:4];
  logic [63:0] isb [0:4];
  logic [63:0] isc [0:4];
  logic [63:0] isd [0:4];
  logic [63:0] ise [0:4];
  logic        sample;
  logic [63:0] osa [0:4];
  logic [63:0] osb [0:4];
  logic [63:0] osc [0:4];
  logic [63:0] osd [0:4];
  logic [63:0] ose [0:4];
  logic        good;
  logic        busy;
`ifdef SHA3_CHI_OVERRUN_EN
  logic        overrun;
`endif

  modport master (
    output isa, isb, isc, isd, ise, sample,
    input  osa, osb, osc, osd, ose, good, busy
`ifdef SHA3_CHI_OVERRUN_EN
    , input overrun
`endif
  );

  modport slave (
    input  isa, isb, isc, isd, ise, sample,
    output osa, osb, osc, osd, ose, good, busy
`ifdef SHA3_CHI_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/sha3_chi.sv
// Keccak chi round stage; SHA3_CHI_OVERRUN_EN adds a sticky overrun flag.
// Latency 1 cycle (PLANES_PER_CYCLE=5) or 6 cycles plane-serial (PLANES_PER_CYCLE=1).
// No backpressure: a sample while busy is dropped; busy is constant 0 in parallel mode.
module sha3_chi #(
  parameter int PLANES_PER_CYCLE = 5,
  parameter     STYLE            = "basic"
) (
  input  logic       clk,
  input  logic       rst,
  sha3_chi_if.slave  io
);

  logic [63:0] in_st [0:4][0:4];  // [y][x]
  logic [63:0] os_q  [0:4][0:4];
  logic        good_q;
  logic        busy_q;
`ifdef SHA3_CHI_OVERRUN_EN
  logic        overrun_q;
`endif

  function automatic logic [63:0] chi_lane(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [63:0] c);
    return a ^ (~b & c);
  endfunction

  generate
    if (!(PLANES_PER_CYCLE == 1 || PLANES_PER_CYCLE == 5) || STYLE != "basic") begin : g_bad_cfg
      $error("sha3_chi: PLANES_PER_CYCLE must be 1 or 5 and STYLE must be \"basic\"");
    end
  endgenerate

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      in_st[0][x] = io.isa[x];
      in_st[1][x] = io.isb[x];
      in_st[2][x] = io.isc[x];
      in_st[3][x] = io.isd[x];
      in_st[4][x] = io.ise[x];
    end
  end

  generate
    if (PLANES_PER_CYCLE == 5) begin : g_par
      logic [63:0] chi_st [0:4][0:4];

      always_comb begin
        for (int y = 0; y < 5; y++) begin
          for (int x = 0; x < 5; x++) begin
            chi_st[y][x] = chi_lane(in_st[y][x], in_st[y][(x + 1) % 5], in_st[y][(x + 2) % 5]);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          good_q <= 1'b0;
          for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
              os_q[y][x] <= '0;
            end
          end
        end else begin
          good_q <= io.sample;
          if (io.sample) begin
            for (int y = 0; y < 5; y++) begin
              for (int x = 0; x < 5; x++) begin
                os_q[y][x] <= chi_st[y][x];
              end
            end
          end
        end
      end

      assign busy_q = 1'b0;
`ifdef SHA3_CHI_OVERRUN_EN
      assign overrun_q = 1'b0;
`endif
    end else begin : g_ser
      typedef enum logic {IDLE, WORK} state_t;

      state_t      state;
      logic [2:0]  row;
      logic [63:0] in_buf   [0:4][0:4];
      logic [63:0] work_buf [0:3][0:4];
      logic [63:0] row_chi  [0:4];

      // The plane selected by row; at row==4 this is the final plane fed straight to os*.
      always_comb begin
        for (int x = 0; x < 5; x++) begin
          row_chi[x] = chi_lane(in_buf[row][x], in_buf[row][(x + 1) % 5], in_buf[row][(x + 2) % 5]);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= IDLE;
          row    <= '0;
          busy_q <= 1'b0;
          good_q <= 1'b0;
          for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
              os_q[y][x] <= '0;
            end
          end
        end else begin
          good_q <= 1'b0;
          case (state)
            IDLE: begin
              if (io.sample) begin
                row    <= '0;
                busy_q <= 1'b1;
                state  <= WORK;
              end
            end
            WORK: begin
              if (row == 3'd4) begin
                for (int x = 0; x < 5; x++) begin
                  for (int y = 0; y < 4; y++) begin
                    os_q[y][x] <= work_buf[y][x];
                  end
                  os_q[4][x] <= row_chi[x];
                end
                good_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end else begin
                row <= row + 3'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end

      // Data buffers carry no reset: they are only observed through os*, which is reset.
      always_ff @(posedge clk) begin
        if (!rst && state == IDLE && io.sample) begin
          for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
              in_buf[y][x] <= in_st[y][x];
            end
          end
        end
        if (!rst && state == WORK && row != 3'd4) begin
          for (int x = 0; x < 5; x++) begin
            work_buf[row[1:0]][x] <= row_chi[x];
          end
        end
      end

`ifdef SHA3_CHI_OVERRUN_EN
      always_ff @(posedge clk) begin
        if (rst) begin
          overrun_q <= 1'b0;
        end else if (io.sample && busy_q) begin
          overrun_q <= 1'b1;
        end
      end
`endif
    end
  endgenerate

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      io.osa[x] = os_q[0][x];
      io.osb[x] = os_q[1][x];
      io.osc[x] = os_q[2][x];
      io.osd[x] = os_q[3][x];
      io.ose[x] = os_q[4][x];
    end
  end

  assign io.good = good_q;
  assign io.busy = busy_q;
`ifdef SHA3_CHI_OVERRUN_EN
  assign io.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_sha3_chi.sv
// Bench for sha3_chi: one parallel and one plane-serial instance share clock, reset and input data.
module tb_sha3_chi;
  typedef logic [1599:0] flat_t;  // lane (y,x) at bits [(5*y+x)*64 +: 64]

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sha3_chi_if if5 ();
  sha3_chi_if if1 ();

  sha3_chi #(.PLANES_PER_CYCLE(5), .STYLE("basic")) dut5 (.clk(clk), .rst(rst), .io(if5.slave));
  sha3_chi #(.PLANES_PER_CYCLE(1), .STYLE("basic")) dut1 (.clk(clk), .rst(rst), .io(if1.slave));

  function automatic logic [63:0] lane(input flat_t s, input int y, input int x);
    return s[(5 * y + x) * 64 +: 64];
  endfunction

  // Reference chi, bit by bit: a bit flips exactly when its right neighbour is 0 and the next one is 1.
  function automatic flat_t chi_ref(input flat_t s);
    flat_t o;
    logic [63:0] a, b, c, r;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        a = lane(s, y, x);
        b = lane(s, y, (x + 1) % 5);
        c = lane(s, y, (x + 2) % 5);
        for (int i = 0; i < 64; i++) begin
          r[i] = (b[i] == 1'b0 && c[i] == 1'b1) ? !a[i] : a[i];
        end
        o[(5 * y + x) * 64 +: 64] = r;
      end
    end
    return o;
  endfunction

  function automatic flat_t rnd_st();
    flat_t o;
    for (int i = 0; i < 50; i++) o[i * 32 +: 32] = $urandom;
    return o;
  endfunction

  function automatic int first_diff(input flat_t a, input flat_t b);
    for (int i = 0; i < 25; i++) begin
      if (a[i * 64 +: 64] !== b[i * 64 +: 64]) return i;
    end
    return 0;
  endfunction

  function automatic flat_t get5();
    flat_t o;
    for (int x = 0; x < 5; x++) begin
      o[(0 + x) * 64 +: 64]  = if5.osa[x];
      o[(5 + x) * 64 +: 64]  = if5.osb[x];
      o[(10 + x) * 64 +: 64] = if5.osc[x];
      o[(15 + x) * 64 +: 64] = if5.osd[x];
      o[(20 + x) * 64 +: 64] = if5.ose[x];
    end
    return o;
  endfunction

  function automatic flat_t get1();
    flat_t o;
    for (int x = 0; x < 5; x++) begin
      o[(0 + x) * 64 +: 64]  = if1.osa[x];
      o[(5 + x) * 64 +: 64]  = if1.osb[x];
      o[(10 + x) * 64 +: 64] = if1.osc[x];
      o[(15 + x) * 64 +: 64] = if1.osd[x];
      o[(20 + x) * 64 +: 64] = if1.ose[x];
    end
    return o;
  endfunction

  task automatic set_in(input flat_t s);
    for (int x = 0; x < 5; x++) begin
      if5.isa[x] = lane(s, 0, x); if1.isa[x] = lane(s, 0, x);
      if5.isb[x] = lane(s, 1, x); if1.isb[x] = lane(s, 1, x);
      if5.isc[x] = lane(s, 2, x); if1.isc[x] = lane(s, 2, x);
      if5.isd[x] = lane(s, 3, x); if1.isd[x] = lane(s, 3, x);
      if5.ise[x] = lane(s, 4, x); if1.ise[x] = lane(s, 4, x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sample once on the serial instance and watch 10 cycles: good count, edges from accept to good, result.
  task automatic serial_run(input flat_t s, output int ng, output int lat, output flat_t res);
    set_in(s);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    set_in(rnd_st());
    ng = 0; lat = -1; res = '0;
    for (int c = 0; c < 10; c++) begin
      if (if1.good === 1'b1) begin
        ng++;
        if (lat < 0) begin lat = c; res = get1(); end
      end
      step();
    end
  endtask

  task automatic test_reset();
    flat_t got;
    int d;
    rst = 1'b1;
    step(); step(); step();
    got = get5(); n_tests++;
    if (got !== '0) begin
      n_fail++; d = first_diff(got, '0);
      $display("FAIL reset_os_par: lane %0d got %h expected 0", d, got[d * 64 +: 64]);
    end
    got = get1(); n_tests++;
    if (got !== '0) begin
      n_fail++; d = first_diff(got, '0);
      $display("FAIL reset_os_ser: lane %0d got %h expected 0", d, got[d * 64 +: 64]);
    end
    n_tests++;
    if ({if5.good, if5.busy, if1.good, if1.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got good/busy par=%b%b ser=%b%b expected 0000", if5.good, if5.busy, if1.good, if1.busy);
    end
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if ({if5.overrun, if1.overrun} !== 2'b00) begin
      n_fail++; $display("FAIL reset_overrun: got %b%b expected 00", if5.overrun, if1.overrun);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int ng, lat;
    flat_t res;
    set_in('0);
    if5.sample = 1'b1;
    step();
    if5.sample = 1'b0;
    n_tests++;
    if (if5.good !== 1'b1 || get5() !== '0) begin
      n_fail++; $display("FAIL zero_par: good %b os_nonzero %b expected good 1 os 0", if5.good, get5() != '0);
    end
    step();
    n_tests++;
    if (if5.good !== 1'b0) begin
      n_fail++; $display("FAIL zero_par_pulse: good %b expected 0", if5.good);
    end
    serial_run('0, ng, lat, res);
    n_tests++;
    if (ng !== 1 || lat !== 5 || res !== '0) begin
      n_fail++; $display("FAIL zero_ser: goods %0d latency %0d os_nonzero %b expected 1 5 0", ng, lat, res != '0);
    end
  endtask

  task automatic test_patterns();
    flat_t s, e, got, res;
    int ng, lat, d;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        s = '1; e = '1;
      end else begin
        s = '0; s[0 +: 64] = 64'd1;
        e = '0; e[0 +: 64] = 64'd1; e[3 * 64 +: 64] = 64'd1;
      end
      set_in(s);
      if5.sample = 1'b1;
      step();
      if5.sample = 1'b0;
      got = get5(); n_tests++;
      if (if5.good !== 1'b1 || got !== e) begin
        n_fail++; d = first_diff(got, e);
        $display("FAIL pattern%0d_par: good %b lane %0d got %h expected %h", p, if5.good, d, got[d * 64 +: 64], e[d * 64 +: 64]);
      end
      serial_run(s, ng, lat, res);
      n_tests++;
      if (ng !== 1 || lat !== 5 || res !== e) begin
        n_fail++; d = first_diff(res, e);
        $display("FAIL pattern%0d_ser: goods %0d latency %0d lane %0d got %h expected %h", p, ng, lat, d, res[d * 64 +: 64], e[d * 64 +: 64]);
      end
    end
  endtask

  task automatic test_back_to_back();
    flat_t s [4];
    flat_t got, e;
    int d;
    for (int i = 0; i < 4; i++) s[i] = rnd_st();
    if5.sample = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(s[i]);
      step();
      if (i == 3) if5.sample = 1'b0;
      got = get5(); e = chi_ref(s[i]); n_tests++;
      if (if5.good !== 1'b1 || if5.busy !== 1'b0 || got !== e) begin
        n_fail++; d = first_diff(got, e);
        $display("FAIL b2b_%0d: good %b busy %b lane %0d got %h expected %h", i, if5.good, if5.busy, d, got[d * 64 +: 64], e[d * 64 +: 64]);
      end
    end
    set_in(rnd_st());
    step();
    n_tests++;
    if (if5.good !== 1'b0 || get5() !== chi_ref(s[3])) begin
      n_fail++; $display("FAIL b2b_hold: good %b held %b expected good 0 held 1", if5.good, get5() === chi_ref(s[3]));
    end
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if (if5.overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overrun_par: got %b expected 0", if5.overrun);
    end
`endif
  endtask

  task automatic test_serial_timing();
    flat_t prev, s, s2, got;
    int d;
    prev = get1();
    s = rnd_st(); s2 = rnd_st();
    set_in(s);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    set_in(rnd_st());
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (if1.busy !== 1'b1 || if1.good !== 1'b0 || get1() !== prev) begin
        n_fail++; $display("FAIL timing_wait_k%0d: busy %b good %b os_held %b expected 1 0 1", c, if1.busy, if1.good, get1() === prev);
      end
      step();
    end
    got = get1(); n_tests++;
    if (if1.busy !== 1'b0 || if1.good !== 1'b1 || got !== chi_ref(s)) begin
      n_fail++; d = first_diff(got, chi_ref(s));
      $display("FAIL timing_done: busy %b good %b lane %0d got %h expected %h", if1.busy, if1.good, d, got[d * 64 +: 64], lane(chi_ref(s), d / 5, d % 5));
    end
    set_in(s2);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    n_tests++;
    if (if1.busy !== 1'b1 || if1.good !== 1'b0) begin
      n_fail++; $display("FAIL timing_k6_accept: busy %b good %b expected 1 0", if1.busy, if1.good);
    end
    repeat (5) step();
    got = get1(); n_tests++;
    if (if1.good !== 1'b1 || got !== chi_ref(s2)) begin
      n_fail++; d = first_diff(got, chi_ref(s2));
      $display("FAIL timing_second: good %b lane %0d got %h expected %h", if1.good, d, got[d * 64 +: 64], lane(chi_ref(s2), d / 5, d % 5));
    end
  endtask

  task automatic test_serial_ignore();
    flat_t sa, sb, res, e;
    int ng, d;
    sa = rnd_st(); sb = rnd_st(); e = chi_ref(sa);
    set_in(sa);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    step();
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if (if1.overrun !== 1'b0) begin
      n_fail++; $display("FAIL ignore_overrun_pre: got %b expected 0", if1.overrun);
    end
`endif
    set_in(sb);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    step();
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if (if1.overrun !== 1'b1) begin
      n_fail++; $display("FAIL ignore_overrun_set: got %b expected 1", if1.overrun);
    end
`endif
    ng = 0; res = '0;
    for (int c = 0; c < 8; c++) begin
      if (if1.good === 1'b1) begin ng++; res = get1(); end
      step();
    end
    n_tests++;
    if (ng !== 1 || res !== e || if1.busy !== 1'b0) begin
      n_fail++; d = first_diff(res, e);
      $display("FAIL ignore_result: goods %0d busy %b lane %0d got %h expected %h", ng, if1.busy, d, res[d * 64 +: 64], e[d * 64 +: 64]);
    end
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if (if1.overrun !== 1'b1) begin
      n_fail++; $display("FAIL ignore_overrun_sticky: got %b expected 1", if1.overrun);
    end
`endif
  endtask

  task automatic test_serial_reset();
    flat_t s, s2, res, e;
    int ng, lat, d;
    s = rnd_st(); s2 = rnd_st(); e = chi_ref(s2);
    set_in(s);
    if1.sample = 1'b1;
    step();
    if1.sample = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (if1.busy !== 1'b0 || if1.good !== 1'b0 || get1() !== '0 || get5() !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: busy %b good %b ser_zero %b par_zero %b expected 0 0 1 1", if1.busy, if1.good, get1() === '0, get5() === '0);
    end
`ifdef SHA3_CHI_OVERRUN_EN
    n_tests++;
    if (if1.overrun !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_overrun: got %b expected 0", if1.overrun);
    end
`endif
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      if (if1.good === 1'b1) ng++;
      step();
    end
    n_tests++;
    if (ng !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_good: goods %0d expected 0", ng);
    end
    serial_run(s2, ng, lat, res);
    n_tests++;
    if (ng !== 1 || lat !== 5 || res !== e) begin
      n_fail++; d = first_diff(res, e);
      $display("FAIL rst_fresh: goods %0d latency %0d lane %0d got %h expected %h", ng, lat, d, res[d * 64 +: 64], e[d * 64 +: 64]);
    end
  endtask

  initial begin
    if5.sample = 1'b0;
    if1.sample = 1'b0;
    set_in('0);
    test_reset();
    test_zero();
    test_patterns();
    test_back_to_back();
    test_serial_timing();
    test_serial_ignore();
    test_serial_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
